// File: rtl/img_pkg.sv
// Shared definitions for the camera frame sequencing path.
//   IMG_WIDTH / IMG_HEIGHT : default image size in pixels
//   IMG_IDX_W              : width of an x or y coordinate
//   FRAME_CNT_W            : width of the completed-frame counter
//   seqState_e             : frame sequencer state encoding
package img_pkg;
  localparam int IMG_WIDTH   = 768;
  localparam int IMG_HEIGHT  = 512;
  localparam int IMG_IDX_W   = 11;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READOUT = 2'd2,
    DONE    = 2'd3
  } seqState_e;
endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y coordinate counter.
//   CAMERA_CLK   : clock, rising edge
//   clear        : synchronous return to (0,0), highest priority
//   en           : advance one pixel in raster order
//   load         : take (loadX,loadY) as the base coordinate this cycle;
//                  combined with en the counter lands on its successor
//   x, y         : current coordinate
//   last         : current coordinate is (WIDTH-1, HEIGHT-1)
module raster_counter
  import img_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int IDX_W  = IMG_IDX_W
) (
  input  logic             CAMERA_CLK,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [IDX_W-1:0] loadX,
  input  logic [IDX_W-1:0] loadY,
  output logic [IDX_W-1:0] x,
  output logic [IDX_W-1:0] y,
  output logic             last
);
  localparam logic [IDX_W-1:0] X_MAX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] Y_MAX = IDX_W'(HEIGHT - 1);

  logic [IDX_W-1:0] baseX, baseY, nextX, nextY;

  always_comb begin
    baseX = load ? loadX : x;
    baseY = load ? loadY : y;
    nextX = baseX;
    nextY = baseY;
    if (en) begin
      // >= rather than == so an out-of-range loaded coordinate still wraps
      if (baseX >= X_MAX) begin
        nextX = '0;
        nextY = (baseY >= Y_MAX) ? '0 : baseY + IDX_W'(1);
      end else begin
        nextX = baseX + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge CAMERA_CLK) begin
    if (clear) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= nextX;
      y <= nextY;
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);
endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: captures one camera frame into an external frame buffer,
// then reads it back in raster order to a processing stage.
//   CAMERA_CLK, rst        : clock / synchronous active-high reset
//   start, continuous      : begin a frame / auto-restart after readout
//   cam_valid, cam_x/y     : incoming camera pixel and its coordinate
//   fb_write_en            : 1 while the camera owns the frame buffer
//   fb_rd_en, fb_rd_x/y    : frame buffer read strobe and address
//   px_valid, px_x/y       : readout pixel tag, 1-cycle after fb_rd_en
//   px_ready               : processing stage accepts px_*
//   busy, frame_done       : not-idle flag / one-cycle end-of-frame pulse
//   seq_error              : sticky camera out-of-order flag
//   frame_count            : completed frames (wrapping)
//   dbgState               : current sequencer state
// Readout handshake: px_* is offered while px_valid=1 and transfers on a
// cycle with px_valid&px_ready; while px_valid=1 and px_ready=0 the tag
// holds stable and no new read is issued.
module frame_seq_ctrl
  import img_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int IDX_W  = IMG_IDX_W
) (
  input  logic                   CAMERA_CLK,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   cam_valid,
  input  logic [IDX_W-1:0]       cam_x,
  input  logic [IDX_W-1:0]       cam_y,
  output logic                   fb_write_en,
  output logic                   fb_rd_en,
  output logic [IDX_W-1:0]       fb_rd_x,
  output logic [IDX_W-1:0]       fb_rd_y,
  output logic                   px_valid,
  output logic [IDX_W-1:0]       px_x,
  output logic [IDX_W-1:0]       px_y,
  input  logic                   px_ready,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   seq_error,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output seqState_e              dbgState
);
  localparam logic [IDX_W-1:0] X_MAX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] Y_MAX = IDX_W'(HEIGHT - 1);

  seqState_e        state;
  logic [IDX_W-1:0] expX, expY;
  logic             expLast, rdLast, issuedAll;
  logic             capAccept, capMatch, camAtLast, capEnd, rdEnd;

  assign capAccept = (state == CAPTURE) && cam_valid;
  assign capMatch  = (cam_x == expX) && (cam_y == expY);
  assign camAtLast = (cam_x == X_MAX) && (cam_y == Y_MAX);
  // An in-order pixel is last exactly when the expected counter is; after a
  // skip the received coordinate itself decides.
  assign capEnd    = capAccept && (capMatch ? expLast : camAtLast);
  assign rdEnd     = px_valid && px_ready && (px_x == X_MAX) && (px_y == Y_MAX);

  // Read strobe must see this cycle's px_ready, so it is decoded rather than
  // registered; it only depends on registered state plus that input.
  assign fb_rd_en  = (state == READOUT) && !issuedAll && (!px_valid || px_ready);
  assign dbgState  = state;

  // Expected camera coordinate; on a mismatch it resynchronises to the
  // successor of the received coordinate.
  raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .IDX_W(IDX_W)) u_capCnt (
    .CAMERA_CLK (CAMERA_CLK),
    .clear      (rst || (state != CAPTURE)),
    .en         (capAccept),
    .load       (capAccept && !capMatch),
    .loadX      (cam_x),
    .loadY      (cam_y),
    .x          (expX),
    .y          (expY),
    .last       (expLast)
  );

  // Readout address, advanced by each issued read.
  raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .IDX_W(IDX_W)) u_rdCnt (
    .CAMERA_CLK (CAMERA_CLK),
    .clear      (rst || (state != READOUT)),
    .en         (fb_rd_en),
    .load       (1'b0),
    .loadX      ('0),
    .loadY      ('0),
    .x          (fb_rd_x),
    .y          (fb_rd_y),
    .last       (rdLast)
  );

  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      state       <= IDLE;
      fb_write_en <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      seq_error   <= 1'b0;
      frame_count <= '0;
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      issuedAll   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (capAccept && !capMatch) seq_error <= 1'b1;

      // One-deep output register between the frame buffer and the stage.
      if (fb_rd_en) begin
        px_valid <= 1'b1;
        px_x     <= fb_rd_x;
        px_y     <= fb_rd_y;
      end else if (px_ready) begin
        px_valid <= 1'b0;
      end
      if (fb_rd_en && rdLast) issuedAll <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state       <= CAPTURE;
            fb_write_en <= 1'b1;
            busy        <= 1'b1;
          end
        end
        CAPTURE: begin
          if (capEnd) begin
            state       <= READOUT;
            fb_write_en <= 1'b0;
          end
        end
        READOUT: begin
          if (rdEnd) begin
            state       <= DONE;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 1'b1;
            issuedAll   <= 1'b0;
          end
        end
        DONE: begin
          if (continuous) begin
            state       <= CAPTURE;
            fb_write_en <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
